// File: rtl/ee271_vm_change_dispenser.sv
// Coin change dispenser: pays a cents amount as timed quarter/dime/nickel ejector pulses,
// largest coin first, with tube inventory tracking. Optional running total: CHANGE_TOTAL_EN.
module ee271_vm_change_dispenser #(
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int CNT_W     = 5,
  parameter int Q_INIT    = 10,
  parameter int D_INIT    = 10,
  parameter int N_INIT    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       change_in,
  input  logic             refill,
  output logic             busy,
  output logic             done,
  output logic             short_flag,
  output logic             err_flag,
  output logic [5:0]       owed,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt,
  output logic [11:0]      total_cents
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_PULSE, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {C_Q, C_D, C_N} coin_t;

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  state_t           r_state;
  coin_t            r_coin;
  logic [TMR_W-1:0] r_tmr;
  logic [5:0]       r_rem;
  logic             r_err_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_short;
  logic             r_err;
  logic [5:0]       r_owed;
  logic             r_eject_q;
  logic             r_eject_d;
  logic             r_eject_n;
  logic [CNT_W-1:0] r_q_cnt;
  logic [CNT_W-1:0] r_d_cnt;
  logic [CNT_W-1:0] r_n_cnt;

  logic [5:0]       w_coin_val;
  logic             w_bad_amt;
  logic             w_coin_counted;

  always_comb begin
    w_coin_val = 6'd5;
    case (r_coin)
      C_Q:     w_coin_val = 6'd25;
      C_D:     w_coin_val = 6'd10;
      default: w_coin_val = 6'd5;
    endcase
  end

  assign w_bad_amt      = (6'(change_in % 6'd5) != 6'd0);
  assign w_coin_counted = (r_state == S_PULSE) && (r_tmr == PULSE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_coin     <= C_Q;
      r_tmr      <= '0;
      r_rem      <= '0;
      r_err_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_short    <= 1'b0;
      r_err      <= 1'b0;
      r_owed     <= '0;
      r_eject_q  <= 1'b0;
      r_eject_d  <= 1'b0;
      r_eject_n  <= 1'b0;
      r_q_cnt    <= CNT_W'(Q_INIT);
      r_d_cnt    <= CNT_W'(D_INIT);
      r_n_cnt    <= CNT_W'(N_INIT);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem      <= change_in;
            r_err_pend <= w_bad_amt;
            r_busy     <= 1'b1;
            r_short    <= 1'b0;
            r_err      <= 1'b0;
            r_owed     <= '0;
            r_state    <= S_CALC;
          end else if (refill) begin
            r_q_cnt <= '1;
            r_d_cnt <= '1;
            r_n_cnt <= '1;
          end
        end

        // Largest coin that still fits and is stocked; otherwise finish.
        S_CALC: begin
          r_tmr <= '0;
          if (r_err_pend) begin
            r_err   <= 1'b1;
            r_owed  <= r_rem;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_rem >= 6'd25 && r_q_cnt != '0) begin
            r_coin    <= C_Q;
            r_eject_q <= 1'b1;
            r_state   <= S_PULSE;
          end else if (r_rem >= 6'd10 && r_d_cnt != '0) begin
            r_coin    <= C_D;
            r_eject_d <= 1'b1;
            r_state   <= S_PULSE;
          end else if (r_rem >= 6'd5 && r_n_cnt != '0) begin
            r_coin    <= C_N;
            r_eject_n <= 1'b1;
            r_state   <= S_PULSE;
          end else if (r_rem == 6'd0) begin
            r_owed  <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_short <= 1'b1;
            r_owed  <= r_rem;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_PULSE: begin
          if (r_tmr == PULSE_LAST) begin
            r_eject_q <= 1'b0;
            r_eject_d <= 1'b0;
            r_eject_n <= 1'b0;
            r_rem     <= r_rem - w_coin_val;
            case (r_coin)
              C_Q:     if (r_q_cnt != '0) r_q_cnt <= r_q_cnt - 1'b1;
              C_D:     if (r_d_cnt != '0) r_d_cnt <= r_d_cnt - 1'b1;
              default: if (r_n_cnt != '0) r_n_cnt <= r_n_cnt - 1'b1;
            endcase
            r_tmr   <= '0;
            r_state <= (GAP_CYC == 0) ? S_CALC : S_GAP;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end

        S_GAP: begin
          if (r_tmr == GAP_LAST) begin
            r_tmr   <= '0;
            r_state <= S_CALC;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CHANGE_TOTAL_EN
  logic [11:0] r_total;

  // Wraps modulo 4096; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total <= '0;
    end else if (w_coin_counted) begin
      r_total <= r_total + {6'd0, w_coin_val};
    end
  end

  assign total_cents = r_total;
`else
  logic w_unused_total;
  assign w_unused_total = w_coin_counted;
  assign total_cents    = 12'd0;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign short_flag = r_short;
  assign err_flag   = r_err;
  assign owed       = r_owed;
  assign eject_q    = r_eject_q;
  assign eject_d    = r_eject_d;
  assign eject_n    = r_eject_n;
  assign q_cnt      = r_q_cnt;
  assign d_cnt      = r_d_cnt;
  assign n_cnt      = r_n_cnt;

endmodule

// File: tb/tb_ee271_vm_change_dispenser.sv
// Directed bench for ee271_vm_change_dispenser: default instance plus a low-stock instance.
module tb_ee271_vm_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] change_in = '0;
  logic       refill = 1'b0;

  logic       busy, done, short_flag, err_flag, eject_q, eject_d, eject_n;
  logic [5:0] owed;
  logic [4:0] q_cnt, d_cnt, n_cnt;
  logic [11:0] total_cents;

  logic       b2_busy, b2_done, b2_short, b2_err, b2_eq, b2_ed, b2_en;
  logic [5:0] b2_owed;
  logic [4:0] b2_q, b2_d, b2_n;
  logic [11:0] b2_total;

  int tests_run = 0;
  int tests_failed = 0;

  ee271_vm_change_dispenser dut (
    .clk(clk), .rst(rst), .start(start), .change_in(change_in), .refill(refill),
    .busy(busy), .done(done), .short_flag(short_flag), .err_flag(err_flag), .owed(owed),
    .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
    .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt), .total_cents(total_cents)
  );

  ee271_vm_change_dispenser #(.Q_INIT(0), .D_INIT(1), .N_INIT(0)) dut_low (
    .clk(clk), .rst(rst), .start(start), .change_in(change_in), .refill(refill),
    .busy(b2_busy), .done(b2_done), .short_flag(b2_short), .err_flag(b2_err), .owed(b2_owed),
    .eject_q(b2_eq), .eject_d(b2_ed), .eject_n(b2_en),
    .q_cnt(b2_q), .d_cnt(b2_d), .n_cnt(b2_n), .total_cents(b2_total)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Per-request observations; cycle 0 is the cycle start is presented.
  int q_first, q_last, d_first, d_last, n_first, n_last;
  int done_cyc, multi_hot, busy_c1, low_d_cycles;
  int r_short, r_err, r_owed;

  task automatic do_req(input logic [5:0] ch, input bit noise);
    int cyc;
    q_first = -1; q_last = -1; d_first = -1; d_last = -1; n_first = -1; n_last = -1;
    done_cyc = -1; multi_hot = 0; busy_c1 = -1; low_d_cycles = 0;
    change_in = ch;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 300) begin
      if (cyc == 1) busy_c1 = int'(busy);
      if (eject_q) begin if (q_first < 0) q_first = cyc; q_last = cyc; end
      if (eject_d) begin if (d_first < 0) d_first = cyc; d_last = cyc; end
      if (eject_n) begin if (n_first < 0) n_first = cyc; n_last = cyc; end
      if (b2_ed) low_d_cycles++;
      if ($countones({eject_q, eject_d, eject_n}) > 1) multi_hot++;
      if (done) begin
        done_cyc = cyc;
        r_short = int'(short_flag);
        r_err = int'(err_flag);
        r_owed = int'(owed);
      end
      // Requests that must be ignored while busy.
      start = noise && (cyc == 3 || cyc == 5);
      change_in = (noise && (cyc == 3 || cyc == 5)) ? 6'd50 : ch;
      refill = noise && (cyc == 4);
      tick();
      cyc++;
    end
    start = 1'b0;
    refill = 1'b0;
    check_val("done_within_budget", int'(done_cyc >= 0), 1);
  endtask

  initial begin
    do_reset();
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_eject", int'({eject_q, eject_d, eject_n}), 0);
    check_val("rst_owed", int'(owed), 0);
    check_val("rst_q_cnt", int'(q_cnt), 10);
    check_val("rst_n_cnt", int'(n_cnt), 10);
    check_val("rst_total", int'(total_cents), 0);
    check_val("low_rst_d_cnt", int'(b2_d), 1);

    // 15 cents: normal unit pays D+N; low-stock unit pays one D and comes up short.
    do_req(6'd15, 1'b0);
    check_val("p15_done_cyc", done_cyc, 16);
    check_val("p15_owed", r_owed, 0);
    check_val("p15_d_cnt", int'(d_cnt), 9);
    check_val("p15_n_cnt", int'(n_cnt), 9);
    check_val("low_d_pulse_len", low_d_cycles, 4);
    check_val("low_short", int'(b2_short), 1);
    check_val("low_owed", int'(b2_owed), 5);
    check_val("low_d_cnt", int'(b2_d), 0);
    check_val("low_eject_q_n", int'({b2_eq, b2_en}), 0);

    do_reset();
    do_req(6'd40, 1'b0);
    check_val("p40_busy_c1", busy_c1, 1);
    check_val("p40_q_first", q_first, 2);
    check_val("p40_q_last", q_last, 5);
    check_val("p40_d_first", d_first, 9);
    check_val("p40_d_last", d_last, 12);
    check_val("p40_n_first", n_first, 16);
    check_val("p40_n_last", n_last, 19);
    check_val("p40_done_cyc", done_cyc, 23);
    check_val("p40_short", r_short, 0);
    check_val("p40_owed", r_owed, 0);
    check_val("p40_onehot_viol", multi_hot, 0);
    check_val("p40_cnts", int'({q_cnt, d_cnt, n_cnt}), int'({5'd9, 5'd9, 5'd9}));
    check_val("p40_busy_after", int'(busy), 0);

    do_req(6'd7, 1'b0);
    check_val("p7_done_cyc", done_cyc, 2);
    check_val("p7_err", r_err, 1);
    check_val("p7_owed", r_owed, 7);
    check_val("p7_no_eject", int'(q_first < 0 && d_first < 0 && n_first < 0), 1);
    check_val("p7_cnts", int'({q_cnt, d_cnt, n_cnt}), int'({5'd9, 5'd9, 5'd9}));

    do_req(6'd0, 1'b0);
    check_val("p0_done_cyc", done_cyc, 2);
    check_val("p0_owed", r_owed, 0);
    check_val("p0_flags", int'({short_flag, err_flag}), 0);

    // Reset during the quarter pulse.
    do_reset();
    change_in = 6'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_val("mid_eject_q_c2", int'(eject_q), 1);
    tick();
    rst = 1'b1;
    #1;
    check_val("mid_eject_q", int'(eject_q), 0);
    check_val("mid_q_cnt", int'(q_cnt), 10);
    check_val("mid_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    tick();
    do_req(6'd25, 1'b0);
    check_val("p25_q_first", q_first, 2);
    check_val("p25_q_last", q_last, 5);
    check_val("p25_done_cyc", done_cyc, 9);
    check_val("p25_q_cnt", int'(q_cnt), 9);

    do_req(6'd10, 1'b1);
    check_val("noise_d_first", d_first, 2);
    check_val("noise_done_cyc", done_cyc, 9);
    check_val("noise_q_first", q_first, -1);
    check_val("noise_cnts", int'({q_cnt, d_cnt, n_cnt}), int'({5'd9, 5'd9, 5'd10}));
    tick();
    tick();
    check_val("noise_no_queue", int'(busy), 0);

    refill = 1'b1;
    tick();
    refill = 1'b0;
    check_val("refill_cnts", int'({q_cnt, d_cnt, n_cnt}), int'({5'd31, 5'd31, 5'd31}));

    do_reset();
    do_req(6'd55, 1'b0);
    check_val("p55_owed", r_owed, 0);
    do_req(6'd30, 1'b0);
    check_val("p30_owed", r_owed, 0);
    check_val("p85_cnts", int'({q_cnt, d_cnt, n_cnt}), int'({5'd7, 5'd10, 5'd8}));
`ifdef CHANGE_TOTAL_EN
    check_val("total_85", int'(total_cents), 85);
`else
    check_val("total_tied", int'(total_cents), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
